parallel_input: RTL and testbench

PARALLEL_INPUT -- requirements
Module: parallel_input

---
 rtl/parallel_port_pkg.sv | 25 ++
 rtl/input_sync.sv | 26 ++
 rtl/parallel_input.sv | 152 +++++++++++++++
 tb/tb_parallel_input.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/parallel_port_pkg.sv
// Shared register map for the parallel input port: byte offsets, register selector, lane-mask helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package parallel_port_pkg;

  // Byte offsets of the four 32-bit registers inside the 16-byte window
  localparam logic [3:0] OFF_DATA    = 4'h0;
  localparam logic [3:0] OFF_EDGE    = 4'h4;
  localparam logic [3:0] OFF_RISE_EN = 4'h8;
  localparam logic [3:0] OFF_FALL_EN = 4'hC;

  // Word selector taken from addr[3:2]; values follow the byte offsets above
  typedef enum logic [1:0] {
    REG_DATA    = OFF_DATA[3:2],
    REG_EDGE    = OFF_EDGE[3:2],
    REG_RISE_EN = OFF_RISE_EN[3:2],
    REG_FALL_EN = OFF_FALL_EN[3:2]
  } reg_sel_t;

  // Expand 4 byte-lane enables into a 32-bit bit mask
  function automatic logic [31:0] lane_mask(input logic [3:0] wmask);
    return {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
  endfunction

endpackage

// File: rtl/input_sync.sv
// Two-flop synchronizer for a bus of independent asynchronous bits.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; samples every cycle.
module input_sync #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First flop may go metastable; second flop gives it a cycle to resolve
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/parallel_input.sv
// Memory-mapped 32-bit input port with edge capture and irq; optional debounce via PARALLEL_INPUT_DEBOUNCE_EN.
// Latency: access completes (ready) one cycle after request; pins reach DATA after 2 sync cycles (+ debounce).
// Backpressure: requester holds ren/wen until the single-cycle ready pulse; no new access starts while ready is high.
module parallel_input
  import parallel_port_pkg::*;
#(
  parameter logic [31:0] ADDR         = 32'hf010,
  parameter int          DEBOUNCE_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        wen,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        active,
  input  logic [31:0] io,
  output logic        irq
);

  logic [31:0] sync_in;
  logic [31:0] filtered;
  logic [31:0] prev;
  logic [31:0] edge_q;
  logic [31:0] rise_en;
  logic [31:0] fall_en;
  logic        prime_d;
  logic        primed;
  logic [31:0] edge_set;
  logic [31:0] edge_clr;
  logic [31:0] wr_mask;
  logic [31:0] read_val;
  logic        start;
  logic        do_write;
  logic        do_read;
  reg_sel_t    sel;

  input_sync #(.WIDTH(32)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (io),
    .q   (sync_in)
  );

`ifdef PARALLEL_INPUT_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;

  logic [CNT_W-1:0] div_cnt;
  logic             tick;
  logic [31:0]      last_samp;
  logic             unused_bits;

  assign tick        = (div_cnt == CNT_W'(DEBOUNCE_DIV - 1));
  assign unused_bits = &{1'b0, addr[1:0]};

  // Prescaler, sample register and per-bit two-sample agreement filter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      last_samp <= '0;
      filtered  <= '0;
    end else if (tick) begin
      div_cnt   <= '0;
      last_samp <= sync_in;
      // Bits whose new sample matches the previous one take the new value
      filtered  <= (sync_in & ~(sync_in ^ last_samp)) | (filtered & (sync_in ^ last_samp));
    end else begin
      div_cnt   <= div_cnt + 1'b1;
    end
  end
`else
  logic unused_bits;

  assign filtered    = sync_in;
  assign unused_bits = &{1'b0, addr[1:0], DEBOUNCE_DIV[0]};
`endif

  // Bus decode: window match, register select, one access per ready pulse
  assign active   = (addr[31:4] == ADDR[31:4]);
  assign sel      = reg_sel_t'(addr[3:2]);
  assign start    = (ren | wen) & active & ~ready;
  assign do_write = start & wen;
  assign do_read  = start & ~wen;
  assign wr_mask  = lane_mask(wmask);

  // Read mux over the four registers
  always_comb begin
    read_val = '0;
    case (sel)
      REG_DATA:    read_val = filtered;
      REG_EDGE:    read_val = edge_q;
      REG_RISE_EN: read_val = rise_en;
      REG_FALL_EN: read_val = fall_en;
      default:     read_val = '0;
    endcase
  end

  // Edge detect gated by primed; W1C mask from a write to EDGE
  always_comb begin
    edge_set = '0;
    edge_clr = '0;
    if (primed) begin
      edge_set = (filtered & ~prev & rise_en) | (~filtered & prev & fall_en);
    end
    if (do_write && (sel == REG_EDGE)) begin
      edge_clr = wdata & wr_mask;
    end
  end

  // Bus handshake and registered read data (zero for writes and idle cycles)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= start;
      rdata <= do_read ? read_val : '0;
    end
  end

  // Enable registers, byte-lane masked writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_en <= '0;
      fall_en <= '0;
    end else if (do_write) begin
      if (sel == REG_RISE_EN) rise_en <= (rise_en & ~wr_mask) | (wdata & wr_mask);
      if (sel == REG_FALL_EN) fall_en <= (fall_en & ~wr_mask) | (wdata & wr_mask);
    end
  end

  // Edge capture state: primed delay, previous value, sticky EDGE (set wins over clear), irq
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prime_d <= 1'b0;
      primed  <= 1'b0;
      prev    <= '0;
      edge_q  <= '0;
      irq     <= 1'b0;
    end else begin
      prime_d <= 1'b1;
      primed  <= prime_d;
      prev    <= filtered;
      edge_q  <= (edge_q & ~edge_clr) | edge_set;
      irq     <= |edge_q;
    end
  end

endmodule

// File: tb/tb_parallel_input.sv
// Directed self-checking bench for parallel_input with a scoreboard of expected read data.
// Latency: checks one-cycle access completion and sync/edge/irq timing.
// Backpressure: holds each request until ready, bounded by a cycle budget.
module tb_parallel_input;
  import parallel_port_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_F010;
`ifdef PARALLEL_INPUT_DEBOUNCE_EN
  localparam int SETTLE = 24;
`else
  localparam int SETTLE = 4;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        wen;
  logic        ren;
  logic [31:0] rdata;
  logic        ready;
  logic        active;
  logic [31:0] io;
  logic        irq;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  parallel_input #(
    .ADDR         (BASE),
    .DEBOUNCE_DIV (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .wdata  (wdata),
    .wmask  (wmask),
    .wen    (wen),
    .ren    (ren),
    .rdata  (rdata),
    .ready  (ready),
    .active (active),
    .io     (io),
    .irq    (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n clocks, leaving time at a falling edge
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // One bus access: push expectation, hold request until ready (bounded), pop and compare
  task automatic access(input logic w, input logic r, input logic [3:0] off,
                        input logic [31:0] d, input logic [3:0] m,
                        input logic [31:0] exp_rd, input string tag);
    int          n;
    logic [31:0] e;
    string       t;
    exp_q.push_back(exp_rd);
    tag_q.push_back(tag);
    addr  = BASE + {28'h0, off};
    wdata = d;
    wmask = m;
    wen   = w;
    ren   = r;
    n = 0;
    do begin
      cycles(1);
      n++;
    end while (ready !== 1'b1 && n < 8);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check({t, " latency"}, 32'(n), 32'd1);
    check({t, " rdata"}, rdata, e);
    ren = 1'b0;
    wen = 1'b0;
    cycles(1);
    check({t, " ready pulse"}, {31'b0, ready}, 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    io    = 32'hFFFF_FFFF;
    addr  = 32'h0;
    wdata = 32'h0;
    wmask = 4'h0;
    wen   = 1'b0;
    ren   = 1'b0;
    cycles(3);

    // Reset state
    check("reset ready", {31'b0, ready}, 32'd0);
    check("reset irq", {31'b0, irq}, 32'd0);
    check("reset rdata", rdata, 32'd0);
    check("reset active off-window", {31'b0, active}, 32'd0);
    rst = 1'b0;
    cycles(SETTLE);

    // Pins high through reset, RISE_EN set later: no spurious edges
    access(1'b1, 1'b0, OFF_RISE_EN, 32'hFFFF_FFFF, 4'hF, 32'h0, "rise_en all");
    cycles(SETTLE);
    access(1'b0, 1'b1, OFF_EDGE, 32'h0, 4'h0, 32'h0, "edge after reset");
    check("irq after reset", {31'b0, irq}, 32'd0);
    access(1'b0, 1'b1, OFF_DATA, 32'h0, 4'h0, 32'hFFFF_FFFF, "data all ones");
    access(1'b1, 1'b0, OFF_RISE_EN, 32'h0, 4'hF, 32'h0, "rise_en clear");
    io = 32'h0;
    cycles(SETTLE);

    // Synchronized read of DATA
    io = 32'h0000_00A5;
    cycles(SETTLE);
    access(1'b0, 1'b1, OFF_DATA, 32'h0, 4'h0, 32'h0000_00A5, "data a5");
    access(1'b1, 1'b0, OFF_DATA, 32'h1234_5678, 4'hF, 32'h0, "data write");
    access(1'b0, 1'b1, OFF_DATA, 32'h0, 4'h0, 32'h0000_00A5, "data write ignored");

    // Byte-lane masked write
    access(1'b1, 1'b0, OFF_RISE_EN, 32'hFFFF_FFFF, 4'b0010, 32'h0, "rise_en lane1");
    access(1'b0, 1'b1, OFF_RISE_EN, 32'h0, 4'h0, 32'h0000_FF00, "rise_en lane1 rd");

    // Rising edge on io[0], irq, then W1C
    access(1'b1, 1'b0, OFF_RISE_EN, 32'h1, 4'hF, 32'h0, "rise_en bit0");
    io = 32'h0000_00A4;
    cycles(SETTLE);
    access(1'b0, 1'b1, OFF_EDGE, 32'h0, 4'h0, 32'h0, "fall no fall_en");
    io = 32'h0000_00A5;
    cycles(SETTLE);
    access(1'b0, 1'b1, OFF_EDGE, 32'h0, 4'h0, 32'h1, "edge bit0 set");
    check("irq set", {31'b0, irq}, 32'd1);
    access(1'b1, 1'b0, OFF_EDGE, 32'h1, 4'hF, 32'h0, "edge w1c");
    check("irq cleared", {31'b0, irq}, 32'd0);
    access(1'b0, 1'b1, OFF_EDGE, 32'h0, 4'h0, 32'h0, "edge cleared");

`ifndef PARALLEL_INPUT_DEBOUNCE_EN
    // Falling edge on io[3] and same-cycle W1C: set wins
    access(1'b1, 1'b0, OFF_FALL_EN, 32'h8, 4'hF, 32'h0, "fall_en bit3");
    io = 32'h0000_00AD;
    cycles(SETTLE);
    access(1'b0, 1'b1, OFF_EDGE, 32'h0, 4'h0, 32'h0, "rise bit3 disabled");
    io = 32'h0000_00A5;
    cycles(SETTLE);
    access(1'b0, 1'b1, OFF_EDGE, 32'h0, 4'h0, 32'h8, "edge bit3 set");
    io = 32'h0000_00AD;
    cycles(SETTLE);
    io = 32'h0000_00A5;
    cycles(2);
    access(1'b1, 1'b0, OFF_EDGE, 32'h8, 4'hF, 32'h0, "w1c vs new edge");
    access(1'b0, 1'b1, OFF_EDGE, 32'h0, 4'h0, 32'h8, "set beats clear");
    access(1'b1, 1'b0, OFF_EDGE, 32'h8, 4'b1110, 32'h0, "w1c lane0 masked");
    access(1'b0, 1'b1, OFF_EDGE, 32'h0, 4'h0, 32'h8, "masked clear kept");
    access(1'b1, 1'b0, OFF_EDGE, 32'h8, 4'b0001, 32'h0, "w1c lane0");
    access(1'b0, 1'b1, OFF_EDGE, 32'h0, 4'h0, 32'h0, "lane0 clear");
`endif

    // ren and wen together act as a write with zero rdata
    access(1'b1, 1'b1, OFF_FALL_EN, 32'h2, 4'hF, 32'h0, "ren+wen write");
    access(1'b0, 1'b1, OFF_FALL_EN, 32'h0, 4'h0, 32'h2, "fall_en rd");

    // Held request after ready does not complete again in the ready cycle
    addr = BASE + {28'h0, OFF_FALL_EN};
    ren  = 1'b1;
    cycles(1);
    check("held ready 1st", {31'b0, ready}, 32'd1);
    check("held rdata 1st", rdata, 32'h2);
    cycles(1);
    check("held ready gap", {31'b0, ready}, 32'd0);
    check("held rdata gap", rdata, 32'h0);
    ren = 1'b0;
    cycles(2);

    // Off-window request is ignored
    addr = 32'h0000_F020;
    ren  = 1'b1;
    #1;
    check("active off", {31'b0, active}, 32'd0);
    cycles(3);
    check("off-window ready", {31'b0, ready}, 32'd0);
    ren  = 1'b0;
    addr = BASE + 32'hC;
    #1;
    check("active top word", {31'b0, active}, 32'd1);
    cycles(1);

`ifdef PARALLEL_INPUT_DEBOUNCE_EN
    // Short glitch on io[1] is filtered out
    access(1'b1, 1'b0, OFF_RISE_EN, 32'h2, 4'hF, 32'h0, "rise_en bit1");
    io = 32'h0000_00A5;
    cycles(SETTLE);
    access(1'b1, 1'b0, OFF_EDGE, 32'hFFFF_FFFF, 4'hF, 32'h0, "edge clear all");
    io = 32'h0000_00A7;
    cycles(3);
    io = 32'h0000_00A5;
    cycles(SETTLE);
    access(1'b0, 1'b1, OFF_DATA, 32'h0, 4'h0, 32'h0000_00A5, "glitch data");
    access(1'b0, 1'b1, OFF_EDGE, 32'h0, 4'h0, 32'h0, "glitch edge");
`endif

    // Reset during a pending access aborts it and clears registers
    addr = BASE + {28'h0, OFF_FALL_EN};
    ren  = 1'b1;
    rst  = 1'b1;
    cycles(1);
    check("abort ready", {31'b0, ready}, 32'd0);
    check("abort rdata", rdata, 32'd0);
    ren = 1'b0;
    rst = 1'b0;
    cycles(SETTLE);
    access(1'b0, 1'b1, OFF_FALL_EN, 32'h0, 4'h0, 32'h0, "fall_en after rst");
    access(1'b0, 1'b1, OFF_RISE_EN, 32'h0, 4'h0, 32'h0, "rise_en after rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
